binary_div_seq: RTL and testbench

//   Sequential unsigned restoring divider: the inverse of the 4-bit array multiplier.
//   - Computes Q = A / B and R = A % B, one quotient bit per clock.
//   - start/busy/done handshake; result held until the next accepted start.
//   - Sits beside the multiplier in the arithmetic datapath; shares its operand width.
//

---
 rtl/binary_div_pkg.sv | 21 ++
 rtl/binary_div_seq_step.sv | 28 ++
 rtl/binary_div_seq.sv | 126 ++++++++++++
 tb/tb_binary_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/binary_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, default width and count-width helper.
package binary_div_pkg;

    // Default operand width, shared with the array multiplier.
    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Width of the iteration counter: it must hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CW = cnt_width(DIV_N);

endpackage

// File: rtl/binary_div_seq_step.sv
// One restoring-division iteration, purely combinational.
// Ports: rem/bit_in/b in, rem_next/q_bit out.
module div_step
    import binary_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] rem,
    input  logic         bit_in,
    input  logic [N-1:0] b,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted = {rem, bit_in};
    assign trial   = shifted - {1'b0, b};

    // trial[N] is the borrow out: set means the divisor did not fit,
    // so the shifted partial remainder is kept unchanged.
    assign q_bit = ~trial[N];

    // When no borrow occurs the difference is below b, so it fits in N bits.
    assign rem_next = trial[N] ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/binary_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start, A, B in; busy, done, Q, R, div_by_zero out.
module binary_div_seq
    import binary_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int CNTW = cnt_width(N);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(N);

    div_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [N-1:0]    dq_q, dq_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    r_q, r_d;
    logic            dbz_q, dbz_d;

    logic [N-1:0]    step_rem;
    logic            step_q;
    logic [N-1:0]    dq_shift;

    div_step #(
        .N (N)
    ) u_step (
        .rem      (rem_q),
        .bit_in   (dq_q[N-1]),
        .b        (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign dq_shift = {dq_q[N-2:0], step_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (B == '0) begin
                        // No iterations: publish the divide-by-zero result now.
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        q_d     = '1;
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_FULL;
                        dq_d    = A;
                        dvs_d   = B;
                        rem_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                dq_d  = dq_shift;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    q_d     = dq_shift;
                    r_d     = step_rem;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_binary_div_seq.sv
// Directed bench for binary_div_seq: handshake, latency and results.
// Ends with a sweep over every 4-bit dividend/divisor pair.
module tb_binary_div_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;

    int total = 0;
    int bad = 0;

    binary_div_seq #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .Q           (q),
        .R           (r),
        .div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat, output bit seen,
                             output bit busy_ok, input bit poke);
        lat = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 2) begin
                start = 1;
                a = 4'd15;
                b = 4'd1;
            end
            if (poke && lat == 3) start = 0;
            if (done === 1'b1) seen = 1;
            else if (busy !== 1'b1) busy_ok = 0;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input int eq,
                          input int er, input int edbz,
                          input int elat, input bit poke);
        int lat;
        bit seen;
        bit busy_ok;
        logic [N-1:0] q_at_done;
        @(negedge clk);
        start = 1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start = 0;
        a = ~av;
        b = ~bv;
        wait_done(lat, seen, busy_ok, poke);
        chk({tag, ".done"}, 32'(seen), 1);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".busy_run"}, 32'(busy_ok), 1);
        chk({tag, ".busy_done"}, 32'(busy), 0);
        chk({tag, ".Q"}, 32'(q), eq);
        chk({tag, ".R"}, 32'(r), er);
        chk({tag, ".dbz"}, 32'(dbz), edbz);
        q_at_done = q;
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done), 0);
        chk({tag, ".hold"}, 32'(q), 32'(q_at_done));
    endtask

    initial begin
        int lat;
        bit seen;
        bit busy_ok;
        bit no_done;

        #12;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.Q", 32'(q), 0);
        chk("rst.R", 32'(r), 0);
        chk("rst.dbz", 32'(dbz), 0);
        @(negedge clk);
        rst_n = 1;

        run_op("d13_4", 4'd13, 4'd4, 3, 1, 0, 5, 0);
        run_op("d9_0", 4'd9, 4'd0, 15, 9, 1, 1, 0);
        run_op("d3_9", 4'd3, 4'd9, 0, 3, 0, 5, 0);
        run_op("d15_1", 4'd15, 4'd1, 15, 0, 0, 5, 0);
        run_op("d0_7", 4'd0, 4'd7, 0, 0, 0, 5, 0);
        run_op("poke", 4'd13, 4'd4, 3, 1, 0, 5, 1);

        // Back-to-back: start stays high into the DONE cycle.
        @(negedge clk);
        start = 1;
        a = 4'd14;
        b = 4'd3;
        @(posedge clk);
        #1;
        a = 4'd8;
        b = 4'd2;
        wait_done(lat, seen, busy_ok, 0);
        chk("b2b1.done", 32'(seen), 1);
        chk("b2b1.lat", lat, 5);
        chk("b2b1.Q", 32'(q), 4);
        chk("b2b1.R", 32'(r), 2);
        @(posedge clk);
        #1;
        start = 0;
        a = 4'd0;
        b = 4'd0;
        wait_done(lat, seen, busy_ok, 0);
        chk("b2b2.done", 32'(seen), 1);
        chk("b2b2.lat", lat, 5);
        chk("b2b2.busy", 32'(busy_ok), 1);
        chk("b2b2.Q", 32'(q), 4);
        chk("b2b2.R", 32'(r), 0);

        // Reset in the middle of a division.
        @(negedge clk);
        start = 1;
        a = 4'd13;
        b = 4'd4;
        @(posedge clk);
        #1;
        start = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.done", 32'(done), 0);
        chk("mrst.Q", 32'(q), 0);
        chk("mrst.R", 32'(r), 0);
        chk("mrst.dbz", 32'(dbz), 0);
        @(negedge clk);
        rst_n = 1;
        no_done = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 0;
        end
        chk("mrst.nodone", 32'(no_done), 1);
        run_op("after_rst", 4'd14, 4'd5, 2, 4, 0, 5, 0);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                int eq;
                int er;
                if (bi == 0) begin
                    eq = 15;
                    er = ai;
                end else begin
                    eq = ai / bi;
                    er = ai % bi;
                end
                run_op($sformatf("ex%0d_%0d", ai, bi), 4'(ai), 4'(bi),
                       eq, er, (bi == 0) ? 1 : 0, (bi == 0) ? 1 : 5, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
